// File: rtl/spi_reg_master_if.sv
// Request/response bus between the harness-side requester and spi_reg_master.
interface spi_reg_master_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned REG_W  = 8
) ();
  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        txn_width;
  logic [REG_W-1:0]  wdata;
  logic              busy;
  logic              done;
  logic [REG_W-1:0]  rdata;

  modport master (output start, rw, addr, txn_width, wdata,
                  input  busy, done, rdata);
  modport slave  (input  start, rw, addr, txn_width, wdata,
                  output busy, done, rdata);
endinterface

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator: one command word plus one data word per request, MSB first.
module spi_reg_master #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned REG_W   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_reg_master_if.slave  bus,
  output logic             spi_cs_n,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso
);
  localparam int unsigned SR_W  = 2 * REG_W;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(SR_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic               rw_q, rw_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [REG_W-1:0]   rdata_q, rdata_d;
  logic [REG_W-1:0]   cmd;
  logic [REG_W-1:0]   wdata_sel;
  logic               div_end;

  // Command word: rw in the MSB, width code below it, address in the LSBs.
  always_comb begin
    cmd                 = '0;
    cmd[REG_W-1]        = bus.rw;
    cmd[REG_W-2 -: 2]   = bus.txn_width;
    cmd[ADDR_W-1:0]     = bus.addr;
    wdata_sel           = bus.rw ? bus.wdata : {REG_W{1'b0}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      rw_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      rw_q    <= rw_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q + DIV_W'(1);
    bit_d   = bit_q;
    sr_d    = sr_q;
    rw_d    = rw_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    div_end = (div_q == DIV_W'(CLK_DIV - 1));

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (bus.start) begin
          rw_d    = bus.rw;
          sr_d    = {cmd, wdata_sel};
          mosi_d  = cmd[REG_W-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_end) begin
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (sclk_q) begin
            // Falling edge: advance MOSI, capture MISO held through the high phase.
            sclk_d = 1'b0;
            sr_d   = {sr_q[SR_W-2:0], 1'b0};
            mosi_d = sr_q[SR_W-2];
            if (!rw_q && (bit_q >= BIT_W'(REG_W)))
              rdata_d = {rdata_q[REG_W-2:0], spi_miso};
          end else if (bit_q == BIT_W'(SR_W - 1)) begin
            bit_d   = '0;
            state_d = HOLD;
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            sclk_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (div_end) begin
          div_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        div_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign spi_cs_n  = cs_n_q;
  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: SPI register responder, frame monitor and reference model.
module tb_spi_reg_master;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned REG_W    = 8;
  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned BUSY_CYC = CLK_DIV * (4 * REG_W + 3);

  logic clk = 1'b0;
  logic rst;
  logic spi_cs_n, spi_clk, spi_mosi, spi_miso;

  spi_reg_master_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  spi_reg_master #(.ADDR_W(ADDR_W), .REG_W(REG_W), .CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  resp_regs [8];
  logic [7:0]  mdl_regs  [8];
  logic [7:0]  last_rdata;
  logic [15:0] mon_sh = '0;
  int          mon_n  = 0;
  logic [7:0]  resp_cmd = '0;
  logic [15:0] frames [$];

  initial spi_miso = 1'b0;

  // Responder: collects MOSI on rising SCLK, drives read data after falling SCLK.
  always @(negedge spi_cs_n) begin
    mon_n  = 0;
    mon_sh = '0;
  end

  always @(posedge spi_clk) begin
    if (spi_cs_n === 1'b0) begin
      mon_sh = {mon_sh[14:0], spi_mosi};
      mon_n++;
      if (mon_n == 8) resp_cmd = mon_sh[7:0];
    end
  end

  always @(negedge spi_clk) begin
    if (spi_cs_n === 1'b0 && mon_n >= 8 && mon_n < 16 && !resp_cmd[7])
      spi_miso = resp_regs[resp_cmd[2:0]][3'(15 - mon_n)];
  end

  always @(posedge spi_cs_n) begin
    if (mon_n == 16) begin
      frames.push_back(mon_sh);
      if (mon_sh[15]) resp_regs[mon_sh[10:8]] = mon_sh[7:0];
    end
    mon_n    = 0;
    spi_miso = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and check timing, frame content and read data against the model.
  task automatic do_frame(input logic rw, input logic [2:0] addr, input logic [1:0] w,
                          input logic [7:0] wd, input int poke_at);
    int busy_cyc, done_cnt, pulses, hi_run, lo_run, n_busy;
    logic bad, prev_clk;
    logic [7:0]  cap_rdata;
    logic [15:0] exp_frame, got;
    frames.delete();
    busy_cyc = 0; done_cnt = 0; pulses = 0; hi_run = 0; lo_run = 0;
    bad = 1'b0; prev_clk = 1'b0; cap_rdata = 'x;
    @(negedge clk);
    bus.rw = rw; bus.addr = addr; bus.txn_width = w; bus.wdata = wd; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy === 1'b1 && busy_cyc < 2000) begin
      busy_cyc++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        cap_rdata = bus.rdata;
      end
      if (spi_clk && !prev_clk) begin
        pulses++;
        if (pulses > 1 && lo_run != int'(CLK_DIV)) bad = 1'b1;
        hi_run = 0;
      end
      if (!spi_clk && prev_clk) begin
        if (hi_run != int'(CLK_DIV)) bad = 1'b1;
        lo_run = 0;
      end
      if (spi_clk) hi_run++; else lo_run++;
      prev_clk = spi_clk;
      if (busy_cyc == poke_at) begin
        bus.start = 1'b1; bus.addr = addr ^ 3'd7; bus.rw = ~rw; bus.wdata = ~wd;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_width", 32'(busy_cyc), 32'(BUSY_CYC));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("sclk_pulses", 32'(pulses), 32'd16);
    check("sclk_shape", 32'(bad), 32'd0);
    exp_frame = {rw, w, 2'b00, addr, (rw ? wd : 8'h00)};
    check("frame_count", 32'(frames.size()), 32'd1);
    got = (frames.size() > 0) ? frames[0] : 16'hxxxx;
    check("mosi_frame", 32'(got), 32'(exp_frame));
    if (rw) begin
      mdl_regs[addr] = wd;
      check("resp_reg", 32'(resp_regs[addr]), 32'(wd));
    end else begin
      last_rdata = mdl_regs[addr];
    end
    check("rdata", 32'(cap_rdata), 32'(last_rdata));
    n_busy = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy !== 1'b0) n_busy++;
      @(negedge clk);
    end
    check("idle_after", 32'(n_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  v, wd0;
    logic [7:0]  cap;
    logic [15:0] e0, e1;
    int n, low;

    rst = 1'b1;
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.txn_width = '0; bus.wdata = '0;
    last_rdata = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom);
      resp_regs[i] = v;
      mdl_regs[i]  = v;
    end

    repeat (3) @(negedge clk);
    check("rst_cs_n",  32'(spi_cs_n),  32'd1);
    check("rst_sclk",  32'(spi_clk),   32'd0);
    check("rst_mosi",  32'(spi_mosi),  32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed write: command C5, data A5.
    do_frame(1'b1, 3'd5, 2'd2, 8'hA5, 0);
    check("reg5_a5", 32'(resp_regs[5]), 32'hA5);

    // Directed read: command 63, responder returns 3C.
    resp_regs[3] = 8'h3C;
    mdl_regs[3]  = 8'h3C;
    do_frame(1'b0, 3'd3, 2'd3, 8'h00, 0);
    check("read_3c", 32'(bus.rdata), 32'h3C);

    // Start pulsed mid-frame with other request fields must be ignored.
    do_frame(1'b1, 3'd1, 2'd1, 8'h96, 30);
    do_frame(1'b0, 3'd4, 2'd0, 8'h00, 90);

    for (int i = 0; i < 8; i++)
      do_frame(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 0);

    // Reset during the high phase of bit 6.
    frames.delete();
    @(negedge clk);
    bus.rw = 1'b1; bus.addr = 3'd2; bus.txn_width = 2'd1; bus.wdata = ~mdl_regs[2]; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (mon_n < 7 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit6", 32'(mon_n), 32'd7);
    rst = 1'b1;
    #1;
    check("midrst_cs_n",  32'(spi_cs_n),  32'd1);
    check("midrst_sclk",  32'(spi_clk),   32'd0);
    check("midrst_busy",  32'(bus.busy),  32'd0);
    check("midrst_rdata", 32'(bus.rdata), 32'd0);
    last_rdata = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_noframe", 32'(frames.size()), 32'd0);
    check("midrst_reg2", 32'(resp_regs[2]), 32'(mdl_regs[2]));
    do_frame(1'b1, 3'd2, 2'd1, 8'h5A, 0);

    // Back-to-back write then read with start held high.
    frames.delete();
    wd0 = 8'($urandom);
    @(negedge clk);
    bus.rw = 1'b1; bus.addr = 3'd6; bus.txn_width = 2'd1; bus.wdata = wd0; bus.start = 1'b1;
    @(negedge clk);
    n = 0;
    while (bus.busy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    bus.rw = 1'b0; bus.addr = 3'd1; bus.txn_width = 2'd0; bus.wdata = 8'h00;
    mdl_regs[6] = wd0;
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    low = 0;
    while (bus.busy !== 1'b1 && low < 10) begin
      low++;
      @(negedge clk);
    end
    check("b2b_gap", 32'(low), 32'd1);
    bus.start = 1'b0;
    cap = 'x;
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      if (bus.done === 1'b1) cap = bus.rdata;
      @(negedge clk);
      n++;
    end
    last_rdata = mdl_regs[1];
    e0 = {1'b1, 2'd1, 2'b00, 3'd6, wd0};
    e1 = {1'b0, 2'd0, 2'b00, 3'd1, 8'h00};
    check("b2b_count", 32'(frames.size()), 32'd2);
    check("b2b_frame0", 32'((frames.size() > 0) ? frames[0] : 16'hxxxx), 32'(e0));
    check("b2b_frame1", 32'((frames.size() > 1) ? frames[1] : 16'hxxxx), 32'(e1));
    check("b2b_rdata", 32'(cap), 32'(last_rdata));
    check("b2b_reg6", 32'(resp_regs[6]), 32'(wd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
